// File: rtl/exec_stage_mc_pkg.sv
// bexkat1 definitions used by the execute stage: instruction types, ALU functions,
// multiply/divide operations and the multi-cycle execute FSM states.
package bexkat1Def;

  typedef enum logic [3:0] {
    T_INH    = 4'h0,
    T_INT    = 4'h1,
    T_CMP    = 4'h2,
    T_MOV    = 4'h3,
    T_LDI    = 4'h4,
    T_LOAD   = 4'h5,
    T_STORE  = 4'h6,
    T_BRANCH = 4'h7,
    T_JUMP   = 4'h8,
    T_MULDIV = 4'h9
  } insn_type_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SAR = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_MODU = 2'd2
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } exec_state_t;

  localparam int IR_W = 64;

  function automatic logic muldiv_op_legal(input logic [3:0] op);
    return (op[3:2] == 2'b00) && (op[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational bexkat1 ALU, WIDTH-generic. Carry on subtract is the borrow (a < b unsigned).
module alu_comb
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          alu_func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             zero
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] r;

  assign sum_w = {1'b0, in1} + {1'b0, in2};
  assign dif_w = {1'b0, in1} - {1'b0, in2};
  assign shamt = in2[SH_W-1:0];

  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_func)
      ALU_ADD: begin
        r        = sum_w[WIDTH-1:0];
        carry    = sum_w[WIDTH];
        overflow = (in1[WIDTH-1] == in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SUB: begin
        r        = dif_w[WIDTH-1:0];
        carry    = dif_w[WIDTH];
        overflow = (in1[WIDTH-1] != in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_AND: r = in1 & in2;
      ALU_OR:  r = in1 | in2;
      ALU_XOR: r = in1 ^ in2;
      ALU_SHL: r = in1 << shamt;
      ALU_SHR: r = in1 >> shamt;
      ALU_SAR: r = $unsigned($signed(in1) >>> shamt);
      default: r = '0;
    endcase
  end

  assign result   = r;
  assign negative = r[WIDTH-1];
  assign zero     = (r == '0);

endmodule

// File: rtl/exec_muldiv.sv
// Iterative multiply / unsigned divide engine: WIDTH shift-add or restoring-divide steps.
// Only built when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module exec_muldiv
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             flush,
  input  logic             ack,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  exec_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
        S_BUSY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_DONE;
        end
        S_DONE: if (ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Divide: acc holds the partial remainder, x shifts the dividend out and the quotient in.
  // A zero divisor always passes the trial subtract, giving all-ones / dividend.
  assign rem_shift = {acc_q, x_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, y_q});

  always_ff @(posedge clk_i) begin
    if ((state_q == S_IDLE) && start) begin
      op_q  <= op;
      acc_q <= '0;
      x_q   <= a;
      y_q   <= b;
    end else if (state_q == S_BUSY) begin
      if (op_q == MD_MUL) begin
        if (y_q[0]) acc_q <= acc_q + x_q;
        x_q <= x_q << 1;
        y_q <= y_q >> 1;
      end else begin
        acc_q <= rem_ge ? WIDTH'(rem_shift - {1'b0, y_q}) : rem_shift[WIDTH-1:0];
        x_q   <= {x_q[WIDTH-2:0], rem_ge};
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = (op_q == MD_DIVU) ? x_q : acc_q;

endmodule
`endif

// File: rtl/exec_stage_mc.sv
// bexkat1 handshaked execute stage with optional iterative mul/div.
// Define EXEC_MULDIV_EN to build the mul/div unit; otherwise T_MULDIV retires as illegal.
module exec_stage_mc
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IR_W-1:0]  ir_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] reg_data1_i,
  input  logic [WIDTH-1:0] reg_data2_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] reg_data1_o,
  output logic [1:0]       reg_write_o,
  output logic [2:0]       ccr_o,
  output logic             exc_illegal_o,
  output logic [IR_W-1:0]  ir_o,
  output logic [WIDTH-1:0] pc_o
);
  if ((WIDTH < 16) || ((2 ** CNT_W) <= WIDTH)) begin : g_param_check
    $error("exec_stage_mc: WIDTH must be >= 16 and 2**CNT_W > WIDTH");
  end

  function automatic logic [WIDTH-1:0] fit_ext(input logic [31:0] e);
    logic [WIDTH+31:0] wide;
    wide = {{WIDTH{1'b0}}, e};
    return wide[WIDTH-1:0];
  endfunction

  insn_type_t       itype;
  logic [3:0]       op;
  logic [14:0]      imm;
  logic             size;
  logic [WIDTH-1:0] imm_sext, imm_zext, ext_w, addr, alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_n, alu_v, alu_z;
  alu_op_t          alu_func;

  logic [WIDTH-1:0] nxt_result;
  logic [1:0]       nxt_wr;
  logic             nxt_exc, nxt_ccr_upd, md_go;

  logic             adv, accept;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_result;

  logic             valid_q;
  logic [WIDTH-1:0] result_q, data1_q, pc_q;
  logic [1:0]       wr_q;
  logic [2:0]       ccr_q;
  logic             exc_q;
  logic [IR_W-1:0]  ir_q;

  assign itype    = insn_type_t'(ir_i[31:28]);
  assign op       = ir_i[27:24];
  assign imm      = ir_i[15:1];
  assign size     = ir_i[0];
  assign imm_sext = {{(WIDTH-15){imm[14]}}, imm};
  assign imm_zext = {{(WIDTH-15){1'b0}}, imm};
  assign ext_w    = fit_ext(ir_i[63:32]);
  assign addr     = size ? ext_w : reg_data1_i + (imm_sext << 2);
  assign alu_b    = op[3] ? imm_sext : reg_data2_i;
  assign alu_func = (itype == T_CMP) ? ALU_SUB : alu_op_t'(op[2:0]);

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .alu_func (alu_func),
    .in1      (reg_data1_i),
    .in2      (alu_b),
    .result   (alu_res),
    .carry    (alu_c),
    .negative (alu_n),
    .overflow (alu_v),
    .zero     (alu_z)
  );

  always_comb begin
    nxt_result  = '0;
    nxt_wr      = 2'b00;
    nxt_exc     = 1'b0;
    nxt_ccr_upd = 1'b0;
    md_go       = 1'b0;
    case (itype)
      T_INH:    nxt_result = '0;
      T_INT: begin
        nxt_result = alu_res;
        nxt_wr     = 2'b11;
      end
      T_CMP: begin
        nxt_result  = alu_res;
        nxt_ccr_upd = 1'b1;
      end
      T_MOV: begin
        nxt_result = reg_data2_i;
        case (op)
          4'd0:    nxt_wr  = 2'b11;
          4'd1:    nxt_wr  = 2'b01;
          4'd2:    nxt_wr  = 2'b10;
          default: nxt_exc = 1'b1;
        endcase
      end
      T_LDI: begin
        nxt_result = size ? ext_w : imm_zext;
        nxt_wr     = 2'b11;
      end
      T_LOAD: begin
        nxt_result = addr;
        nxt_wr     = 2'b11;
      end
      T_STORE, T_JUMP: nxt_result = addr;
      T_BRANCH: nxt_result = pc_i + (imm_sext << 2);
`ifdef EXEC_MULDIV_EN
      T_MULDIV: begin
        if (muldiv_op_legal(op)) md_go = 1'b1;
        else                     nxt_exc = 1'b1;
      end
`else
      T_MULDIV: nxt_exc = 1'b1;
`endif
      default:  nxt_exc = 1'b1;
    endcase
  end

  assign adv     = !valid_q || ready_i;
  assign ready_o = adv && !md_busy;
  assign accept  = valid_i && ready_o && !flush_i;

`ifdef EXEC_MULDIV_EN
  exec_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (accept && md_go),
    .flush  (flush_i),
    .ack    (adv),
    .op     (muldiv_op_t'(op[1:0])),
    .a      (reg_data1_i),
    .b      (reg_data2_i),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  // Output register. A mul/div instruction parks its passthrough fields here while
  // valid_q stays low, so only the result needs loading when the engine finishes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      data1_q  <= '0;
      pc_q     <= '0;
      wr_q     <= 2'b00;
      ccr_q    <= 3'b000;
      exc_q    <= 1'b0;
      ir_q     <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (md_done && adv) begin
      valid_q  <= 1'b1;
      result_q <= md_result;
      wr_q     <= 2'b11;
      exc_q    <= 1'b0;
    end else if (accept) begin
      valid_q  <= !md_go;
      result_q <= nxt_result;
      wr_q     <= nxt_wr;
      exc_q    <= nxt_exc;
      ir_q     <= ir_i;
      pc_q     <= pc_i;
      data1_q  <= reg_data1_i;
      if (nxt_ccr_upd) ccr_q <= {alu_c, alu_n ^ alu_v, alu_z};
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o       = valid_q;
  assign result_o      = result_q;
  assign reg_data1_o   = data1_q;
  assign reg_write_o   = wr_q;
  assign ccr_o         = ccr_q;
  assign exc_illegal_o = exc_q;
  assign ir_o          = ir_q;
  assign pc_o          = pc_q;

endmodule
